// File: rtl/execute_stage.sv
// Execute stage of a pipelined ARM-style core: operand forwarding, ALU,
// NZCV flag register, condition evaluation and the execute/memory register.
module execute_stage (
    input  logic        clk,
    input  logic        reset,        // active-low, asynchronous
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    input  logic [31:0] EXTIMM,
    input  logic [3:0]  WA3E,
    input  logic        PCSrcE,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        MemtoRegE,
    input  logic        ALUSrcE,
    input  logic        BranchE,
    input  logic [1:0]  FlagWriteE,   // bit1 = NZ, bit0 = CV
    input  logic [1:0]  ALUControlE,
    input  logic [3:0]  CondE,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ResultW,
    output logic [3:0]  FlagsOut,     // {N, Z, C, V}
    output logic        BranchTakenE,
    output logic [31:0] ALUOutM,
    output logic [31:0] WriteDataM,
    output logic [3:0]  WA3M,
    output logic        PCSrcM,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        MemtoRegM
);

    // Pipeline and flag state
    logic [3:0]  flags_q, flags_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] write_data_q, write_data_d;
    logic [3:0]  wa3_q, wa3_d;
    logic        pc_src_q, pc_src_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;

    // Datapath intermediates
    logic [31:0] src_a;
    logic [31:0] write_data_e;
    logic [31:0] src_b;
    logic [31:0] b_eff;
    logic [32:0] sum;
    logic [31:0] alu_result;
    logic        is_arith;
    logic        alu_n, alu_z, alu_c, alu_v;
    logic        flag_n, flag_z, flag_c, flag_v;
    logic        cond_ex;

    // Forwarding muxes, ALU, condition check and next-state for all registers
    always_comb begin
        // Operand A: forwarded value; ALUOutM is the pre-edge register content
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = alu_out_q;
            default: src_a = RD1;
        endcase

        // Operand B before the immediate mux doubles as store data
        case (ForwardBE)
            2'b01:   write_data_e = ResultW;
            2'b10:   write_data_e = alu_out_q;
            default: write_data_e = RD2;
        endcase

        src_b = ALUSrcE ? EXTIMM : write_data_e;

        // Subtract is A + ~B + 1 so carry/overflow share the adder
        b_eff = (ALUControlE == 2'b01) ? ~src_b : src_b;
        sum   = {1'b0, src_a} + {1'b0, b_eff} + {32'b0, (ALUControlE == 2'b01)};

        case (ALUControlE)
            2'b10:   alu_result = src_a & src_b;
            2'b11:   alu_result = src_a | src_b;
            default: alu_result = sum[31:0];
        endcase

        is_arith = ~ALUControlE[1];
        alu_n    = alu_result[31];
        alu_z    = (alu_result == 32'd0);
        alu_c    = is_arith & sum[32];
        alu_v    = is_arith & (src_a[31] == b_eff[31]) & (alu_result[31] != src_a[31]);

        // Conditions only ever see the registered flags (no same-cycle bypass)
        flag_n = flags_q[3];
        flag_z = flags_q[2];
        flag_c = flags_q[1];
        flag_v = flags_q[0];

        case (CondE)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase

        // Flag groups update independently; failed conditions hold them
        flags_d = flags_q;
        if (FlagWriteE[1] & cond_ex) begin
            flags_d[3] = alu_n;
            flags_d[2] = alu_z;
        end
        if (FlagWriteE[0] & cond_ex) begin
            flags_d[1] = alu_c;
            flags_d[0] = alu_v;
        end

        // Data always loads; side-effecting controls are condition-gated
        alu_out_d    = alu_result;
        write_data_d = write_data_e;
        wa3_d        = WA3E;
        mem_to_reg_d = MemtoRegE;
        pc_src_d     = PCSrcE & cond_ex;
        reg_write_d  = RegWriteE & cond_ex;
        mem_write_d  = MemWriteE & cond_ex;
    end

    // Flag register and execute/memory register, loaded every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q      <= 4'b0000;
            alu_out_q    <= 32'd0;
            write_data_q <= 32'd0;
            wa3_q        <= 4'd0;
            pc_src_q     <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            alu_out_q    <= alu_out_d;
            write_data_q <= write_data_d;
            wa3_q        <= wa3_d;
            pc_src_q     <= pc_src_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    assign FlagsOut     = flags_q;
    assign BranchTakenE = BranchE & cond_ex;
    assign ALUOutM      = alu_out_q;
    assign WriteDataM   = write_data_q;
    assign WA3M         = wa3_q;
    assign PCSrcM       = pc_src_q;
    assign RegWriteM    = reg_write_q;
    assign MemWriteM    = mem_write_q;
    assign MemtoRegM    = mem_to_reg_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus pushes hand-computed expected
// register contents, a monitor pops and compares one entry per clock edge.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] RD1, RD2, EXTIMM, ResultW;
    logic [3:0]  WA3E, CondE;
    logic        PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchE;
    logic [1:0]  FlagWriteE, ALUControlE, ForwardAE, ForwardBE;
    logic [3:0]  FlagsOut;
    logic        BranchTakenE;
    logic [31:0] ALUOutM, WriteDataM;
    logic [3:0]  WA3M;
    logic        PCSrcM, RegWriteM, MemWriteM, MemtoRegM;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string      name;
        logic [75:0] exp;
    } txn_t;

    txn_t sb_q[$];

    execute_stage dut (
        .clk(clk), .reset(reset),
        .RD1(RD1), .RD2(RD2), .EXTIMM(EXTIMM), .WA3E(WA3E),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE), .BranchE(BranchE),
        .FlagWriteE(FlagWriteE), .ALUControlE(ALUControlE), .CondE(CondE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .FlagsOut(FlagsOut), .BranchTakenE(BranchTakenE),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WA3M(WA3M),
        .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .MemtoRegM(MemtoRegM)
    );

    always #5 clk = ~clk;

    // {ALUOutM, WriteDataM, WA3M, PCSrcM, RegWriteM, MemWriteM, MemtoRegM, FlagsOut}
    function automatic logic [75:0] pk(logic [31:0] alu, logic [31:0] wd, logic [3:0] wa3,
                                       logic pcs, logic rw, logic mw, logic m2r, logic [3:0] fl);
        return {alu, wd, wa3, pcs, rw, mw, m2r, fl};
    endfunction

    function automatic logic [75:0] dut_state();
        return {ALUOutM, WriteDataM, WA3M, PCSrcM, RegWriteM, MemWriteM, MemtoRegM, FlagsOut};
    endfunction

    task automatic check(string name, logic [75:0] act, logic [75:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    task automatic clr();
        RD1 = 0; RD2 = 0; EXTIMM = 0; ResultW = 0; WA3E = 0; CondE = 4'b1110;
        PCSrcE = 0; RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0; ALUSrcE = 0; BranchE = 0;
        FlagWriteE = 0; ALUControlE = 0; ForwardAE = 0; ForwardBE = 0;
    endtask

    // Inputs are already driven; queue the expectation and advance one cycle
    task automatic issue(string name, logic [75:0] exp);
        txn_t t;
        t.name = name;
        t.exp  = exp;
        sb_q.push_back(t);
        @(negedge clk);
    endtask

    // Monitor: every edge presents a new execute/memory register value
    initial begin
        txn_t t;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                t = sb_q.pop_front();
                check(t.name, dut_state(), t.exp);
            end
        end
    end

    // Global time bound
    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        reset = 1'b1;
        clr();
        #2 reset = 1'b0;
        #1 check("reset_initial", dut_state(), 76'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #2;

        // After reset NZCV=0000: EQ fails, NE passes
        BranchE = 1; CondE = 4'b0000;
        #1 check("post_reset_eq_branch", {75'd0, BranchTakenE}, 76'd0);
        CondE = 4'b0001;
        #1 check("post_reset_ne_branch", {75'd0, BranchTakenE}, 76'd1);
        clr();

        // Add with signed overflow
        RD1 = 32'h7FFFFFFF; RD2 = 1; FlagWriteE = 2'b11; RegWriteE = 1; MemtoRegE = 1; WA3E = 3;
        issue("add_overflow", pk(32'h80000000, 32'h1, 4'd3, 0, 1, 0, 1, 4'b1001));
        clr();

        // Subtract equal operands: Z=1, C=1
        RD1 = 5; RD2 = 5; ALUControlE = 2'b01; FlagWriteE = 2'b11; WA3E = 4;
        issue("sub_equal", pk(32'h0, 32'h5, 4'd4, 0, 0, 0, 0, 4'b0110));
        clr();

        // NE with Z=1 fails: controls gated, flags hold, data loads
        RD1 = 9; RD2 = 2; CondE = 4'b0001; RegWriteE = 1; MemWriteE = 1; PCSrcE = 1;
        FlagWriteE = 2'b11; BranchE = 1; WA3E = 5;
        #1 check("ne_branch_not_taken", {75'd0, BranchTakenE}, 76'd0);
        issue("ne_fail_gated", pk(32'hB, 32'h2, 4'd5, 0, 0, 0, 0, 4'b0110));
        clr();

        // EQ branch with Z=1 taken, AND op
        RD1 = 1; RD2 = 1; ALUControlE = 2'b10; CondE = 4'b0000; BranchE = 1; PCSrcE = 1; WA3E = 15;
        #1 check("eq_branch_taken", {75'd0, BranchTakenE}, 76'd1);
        issue("eq_branch_pcsrc", pk(32'h1, 32'h1, 4'd15, 1, 0, 0, 0, 4'b0110));
        clr();

        // Forwarding: first put 0x10 in ALUOutM, then consume it
        RD1 = 32'h10;
        issue("fwd_setup", pk(32'h10, 32'h0, 4'd0, 0, 0, 0, 0, 4'b0110));
        clr();
        RD1 = 32'hDEAD; RD2 = 32'hBEEF; ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 3; WA3E = 2;
        issue("fwd_add", pk(32'h13, 32'h3, 4'd2, 0, 0, 0, 0, 4'b0110));
        clr();

        // 0x80000000 - 1: C=1, V=1
        RD1 = 32'h80000000; RD2 = 1; ALUControlE = 2'b01; FlagWriteE = 2'b11;
        issue("sub_overflow", pk(32'h7FFFFFFF, 32'h1, 4'd0, 0, 0, 0, 0, 4'b0011));
        clr();

        // AND to zero with NZ-only write keeps C/V
        RD1 = 32'hF0; RD2 = 32'h0F; ALUControlE = 2'b10; FlagWriteE = 2'b10;
        issue("and_nz_only", pk(32'h0, 32'h0F, 4'd0, 0, 0, 0, 0, 4'b0111));
        clr();

        // Immediate operand with OR; store data is still RD2
        RD1 = 32'h0F; RD2 = 32'hAA; EXTIMM = 32'h100; ALUSrcE = 1; ALUControlE = 2'b11;
        issue("or_imm", pk(32'h10F, 32'hAA, 4'd0, 0, 0, 0, 0, 4'b0111));
        clr();

        // GT with Z=1 fails: flags hold
        RD1 = 1; RD2 = 1; CondE = 4'b1100; RegWriteE = 1; FlagWriteE = 2'b11;
        issue("gt_fail", pk(32'h2, 32'h1, 4'd0, 0, 0, 0, 0, 4'b0111));
        clr();

        // LE with Z=1 passes: 3-5 sets N, clears C
        RD1 = 3; RD2 = 5; ALUControlE = 2'b01; CondE = 4'b1101; RegWriteE = 1; MemWriteE = 1;
        FlagWriteE = 2'b11; WA3E = 6;
        issue("le_pass_sub", pk(32'hFFFFFFFE, 32'h5, 4'd6, 0, 1, 1, 0, 4'b1000));
        clr();

        // New flags visible next cycle: EQ now fails
        RD1 = 4; RD2 = 4; ALUControlE = 2'b11; CondE = 4'b0000; RegWriteE = 1;
        issue("eq_after_update", pk(32'h4, 32'h4, 4'd0, 0, 0, 0, 0, 4'b1000));
        clr();

        // Nonzero state, then reset mid-cycle
        RD1 = 1; RD2 = 2; ALUControlE = 2'b01; FlagWriteE = 2'b11; RegWriteE = 1; MemWriteE = 1;
        MemtoRegE = 1; WA3E = 7;
        issue("pre_reset_load", pk(32'hFFFFFFFF, 32'h2, 4'd7, 0, 1, 1, 1, 4'b1000));
        #2 reset = 1'b0;
        #1 check("async_reset_clear", dut_state(), 76'd0);
        @(posedge clk);
        #1 check("reset_held_over_edge", dut_state(), 76'd0);
        @(negedge clk);
        reset = 1'b1;
        clr();

        // First instruction after reset: EQ fails on NZCV=0000
        RD1 = 2; RD2 = 3; CondE = 4'b0000; RegWriteE = 1; BranchE = 1; WA3E = 1; FlagWriteE = 2'b11;
        #1 check("post_reset2_eq_branch", {75'd0, BranchTakenE}, 76'd0);
        issue("post_reset_first_load", pk(32'h5, 32'h3, 4'd1, 0, 0, 0, 0, 4'b0000));
        clr();

        @(negedge clk);
        check("scoreboard_drained", {44'd0, 32'(sb_q.size())}, 76'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL have one clock: clk  in  1  rising-edge clock for all state.
REQ-002 The block SHALL have one reset: reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-003 The block SHALL have the following execute-side inputs, one per line:
 - RD1, RD2  in  32 each  register operands from the decode/execute register.
 - EXTIMM  in  32  extended immediate.
 - WA3E  in  4  destination register.
 - PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchE  in  1 each  decoded controls.
 - FlagWriteE  in  2  flag-write enables: bit1 = NZ, bit0 = CV.
 - ALUControlE  in  2  ALU operation.
 - CondE  in  4  condition field.
REQ-004 The block SHALL have the following forwarding inputs, one per line:
 - ForwardAE, ForwardBE  in  2 each  operand forwarding selects.
 - ResultW  in  32  writeback result.
REQ-005 The block SHALL have the following outputs, one per line:
 - FlagsOut  out  4  current NZCV register, fed back to decode.
 - BranchTakenE  out  1  combinational taken-branch indication to fetch/hazard logic.
 - ALUOutM, WriteDataM  out  32 each  registered execute results.
 - WA3M  out  4  registered destination register.
 - PCSrcM, RegWriteM, MemWriteM, MemtoRegM  out  1 each  registered, condition-gated controls.

Function
REQ-006 Operand A SHALL be selected by ForwardAE: 00 = RD1, 01 = ResultW, 10 = ALUOutM, 11 = RD1.
REQ-007 Operand B (pre-mux) SHALL be selected by ForwardBE with the same encoding applied to RD2; WriteDataE SHALL equal this value.
REQ-008 SrcB SHALL equal EXTIMM when ALUSrcE=1, else the forwarded B value.
REQ-009 The ALU SHALL implement ALUControlE as follows: 00 = A+B, 01 = A-B (computed A+~B+1), 10 = A&B, 11 = A|B; the result is 32 bits and wraps modulo 2^32.
REQ-010 The ALU flags SHALL be: N = result[31]; Z = (result==0); C = carry-out of bit 31 for add/sub, 0 for logic ops; V = signed overflow for add/sub, 0 for logic ops.
REQ-011 CondExE SHALL be evaluated from the registered NZCV as follows:
 - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
 - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
 - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V.
 - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0.
REQ-012 On the rising clk edge, N and Z SHALL load the ALU N/Z only when FlagWriteE[1]&CondExE; C and V SHALL load only when FlagWriteE[0]&CondExE; otherwise each flag holds.
REQ-013 A flag update SHALL first be visible to the condition check of the following cycle's instruction, with no same-cycle bypass.
REQ-014 BranchTakenE SHALL equal BranchE&CondExE, combinationally, with 0 latency.
REQ-015 On each rising clk edge the block SHALL load the execute/memory register as follows:
 - ALUOutM <= ALU result; WriteDataM <= WriteDataE; WA3M <= WA3E; MemtoRegM <= MemtoRegE.
 - PCSrcM <= PCSrcE&CondExE; RegWriteM <= RegWriteE&CondExE; MemWriteM <= MemWriteE&CondExE.
REQ-016 Latency from execute inputs to the *M outputs SHALL be exactly one cycle; the register SHALL have no stall or enable and loads every cycle.
REQ-017 When a failed condition (CondExE=0) occurs, PCSrcM, RegWriteM and MemWriteM SHALL all be 0 and the flags SHALL hold, while data outputs still load.
REQ-018 Forwarding from ALUOutM SHALL use the register's current (pre-edge) value.

Reset
REQ-019 While reset=0, asynchronously and independent of clk, all outputs SHALL be cleared:
 - the NZCV register SHALL be 0000;
 - all *M outputs SHALL be 0.
REQ-020 On release of reset, the first rising edge SHALL perform a normal load; a reset asserted mid-operation SHALL discard the in-flight execute result.
REQ-021 Immediately after reset, condition checks SHALL use NZCV=0000 (for example, EQ fails and NE passes).

Verification
REQ-022 Reset scenario: assert reset=0 mid-cycle with nonzero state -> FlagsOut=0000 and all *M outputs=0 before the next edge.
REQ-023 Add scenario: RD1=32'h7FFFFFFF, RD2=1, ALUControlE=00, FlagWriteE=11, CondE=1110 -> after one edge ALUOutM=32'h80000000 and FlagsOut=1001 (N=1, V=1).
REQ-024 Subtract/equal scenario: RD1=5, RD2=5, ALUControlE=01, FlagWriteE=11, CondE=1110 -> FlagsOut=0110 (Z=1, C=1); next cycle CondE=0001 with RegWriteE=1 -> RegWriteM=0.
REQ-025 Branch scenario: with Z=1, BranchE=1, PCSrcE=1, CondE=0000 -> BranchTakenE=1 in the same cycle and PCSrcM=1 after the edge; CondE=0001 -> both 0.
REQ-026 Forwarding scenario: ForwardAE=10 with ALUOutM=32'h10, ForwardBE=01 with ResultW=32'h3, ALUSrcE=0, ALUControlE=00 -> ALUOutM=32'h13 and WriteDataM=32'h3.
REQ-027 Logic/partial-write scenario: with C=1, V=1, AND result 0 and FlagWriteE=10 -> N=0, Z=1, C/V unchanged (FlagsOut=0111).
